ring_fifo: RTL and testbench
============================

RING_FIFO -- requirements
Module: ring_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 32, number of entries; power of two, >=2.
REQ-003 Parameter AF_LVL, default DEPTH-1; a_full asserts when count >= AF_LVL.
REQ-004 Parameter AE_LVL, default 1; a_empty asserts when count <= AE_LVL.
REQ-005 Parameter FWFT, default 0; 0 = registered pop data, 1 = first-word-fall-through (show-ahead).
REQ-006 Localparam CNT = $clog2(DEPTH).
REQ-007 clk  in  1  sole clock, all state on rising edge.
REQ-008 rst  in  1  reset, asynchronous assert, active-high.
REQ-009 clr  in  1  synchronous flush: empties FIFO, clears error flags.
REQ-010 push  in  1  write strobe; din captured when accepted.
REQ-011 din  in  WIDTH  write data.
REQ-012 pop  in  1  read strobe.
REQ-013 dout  out  WIDTH  read data (timing per FWFT).
REQ-014 full, a_full, empty, a_empty  out  1 each  status flags.
REQ-015 count  out  CNT+1  current occupancy, 0..DEPTH.
REQ-016 ovf, udf  out  1 each  sticky overflow / underflow error flags.

Function
REQ-017 Storage SHALL be a circular buffer with CNT-bit read and write pointers; no entry shifting.
REQ-018 Pointers SHALL wrap from DEPTH-1 to 0 modulo DEPTH.
REQ-019 Push accepted iff push=1 and full=0; din written at wr_ptr, wr_ptr+1.
REQ-020 Pop accepted iff pop=1 and empty=0; rd_ptr+1.
REQ-021 Simultaneous accepted push and pop SHALL both occur in the same cycle; count unchanged.
REQ-022 When full, push is rejected even if pop is accepted the same cycle; pop proceeds.
REQ-023 When empty, pop is rejected even if push is accepted the same cycle; push proceeds.
REQ-024 count SHALL be +1 on push-only, -1 on pop-only, unchanged otherwise.
REQ-025 full = (count==DEPTH); empty = (count==0); all flags derived combinationally from registered count.
REQ-026 FWFT=0: on accepted pop, dout SHALL load the head entry at the next rising edge (1-cycle latency) and hold otherwise.
REQ-027 FWFT=1: dout SHALL present the head entry combinationally whenever empty=0; a word pushed into an empty FIFO is visible the cycle after the push edge; dout is don't-care while empty.
REQ-028 ovf SHALL set on push=1 with full=1 and not clear until clr or rst.
REQ-029 udf SHALL set on pop=1 with empty=1 and not clear until clr or rst.
REQ-030 clr SHALL take priority over push/pop that cycle: pointers, count, ovf, udf to 0; storage contents unchanged; dout unchanged.

Reset
REQ-031 rst=1 SHALL immediately force rd_ptr, wr_ptr, count, ovf, udf to 0 and dout (FWFT=0 register) to 0.
REQ-032 During and after reset: empty=1, a_empty=1, full=0, a_full=0 (given AF_LVL>=1).
REQ-033 Storage array SHALL NOT be reset; no read of unwritten entries is observable.
REQ-034 Reset asserted mid-operation SHALL discard all contents; first push after deassert lands at entry 0.

Structure
REQ-035 Package ring_fifo_pkg SHALL hold default WIDTH/DEPTH constants and a function computing CNT.
REQ-036 Storage SHALL be a sub-module ring_fifo_ram: one write port, one asynchronous read port, no reset.
REQ-037 Illegal parameters (DEPTH not power of two, AF_LVL>DEPTH, AE_LVL>=DEPTH) SHALL fail elaboration.

Verification
REQ-038 Fill: DEPTH=4, FWFT=0, push 0xA1..0xA4 -> full=1 after 4th edge, count=4, a_full=1 after 3rd; then pop x4 -> dout A1,A2,A3,A4 one cycle after each pop, empty=1.
REQ-039 Wrap: DEPTH=4, 10 interleaved push/pop pairs of 0x00..0x09 -> output order preserved, count never exceeds 4.
REQ-040 Simultaneous: count=2, push=pop=1 for 3 cycles -> count stays 2, data ordered; at full with push=pop=1 -> count=3, ovf=1.
REQ-041 Errors: pop while empty -> udf=1, count 0; clr pulse -> ovf=udf=0, empty=1.
REQ-042 FWFT=1: push 0x5C into empty -> dout=0x5C next cycle without pop; pop -> empty=1.
REQ-043 Reset mid-run: count=3, assert rst between edges -> count=0, empty=1 immediately; push 0x77, pop -> dout=0x77.

Source files
------------

// File: rtl/ring_fifo_pkg.sv
// Shared constants and helpers for the ring_fifo circular-buffer FIFO.
package ring_fifo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 32;

    // Pointer width for a power-of-two DEPTH.
    function automatic int unsigned cnt_bits(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ring_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module ring_fifo_ram
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ring_fifo.sv
// Circular-buffer FIFO with occupancy count, level flags, sticky error flags
// and selectable registered or first-word-fall-through read data.
module ring_fifo
    import ring_fifo_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned AF_LVL = DEPTH - 1,
    parameter int unsigned AE_LVL = 1,
    parameter int unsigned FWFT   = 0,
    localparam int unsigned CNT   = cnt_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             a_full,
    output logic             empty,
    output logic             a_empty,
    output logic [CNT:0]     count,
    output logic             ovf,
    output logic             udf
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $fatal(1, "ring_fifo: WIDTH must be >= 1");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "ring_fifo: DEPTH must be a power of two >= 2");
        end
        if (AF_LVL > DEPTH) begin : g_bad_af
            $fatal(1, "ring_fifo: AF_LVL must not exceed DEPTH");
        end
        if (AE_LVL >= DEPTH) begin : g_bad_ae
            $fatal(1, "ring_fifo: AE_LVL must be below DEPTH");
        end
    endgenerate

    localparam logic [CNT:0]   DEPTH_C = (CNT+1)'(DEPTH);
    localparam logic [CNT:0]   AF_C    = (CNT+1)'(AF_LVL);
    localparam logic [CNT:0]   AE_C    = (CNT+1)'(AE_LVL);
    localparam logic [CNT:0]   CNT_ONE = (CNT+1)'(1);
    localparam logic [CNT-1:0] PTR_ONE = CNT'(1);

    logic [CNT-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT:0]     count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             push_ok, pop_ok;
    logic [WIDTH-1:0] rd_data;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign a_full  = (count_q >= AF_C);
    assign a_empty = (count_q <= AE_C);
    assign count   = count_q;
    assign ovf     = ovf_q;
    assign udf     = udf_q;

    // Acceptance is judged on pre-edge flags, so a pop cannot make room for a
    // same-cycle push into a full FIFO, nor a push feed a same-cycle pop.
    assign push_ok = push && !full && !clr;
    assign pop_ok  = pop && !empty && !clr;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push && full) begin
                ovf_d = 1'b1;
            end
            if (pop && empty) begin
                udf_d = 1'b1;
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    ring_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (CNT)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    generate
        if (FWFT == 0) begin : g_reg_dout
            logic [WIDTH-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = dout_q;
                if (pop_ok) begin
                    dout_d = rd_data;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign dout = dout_q;
        end else begin : g_fwft_dout
            assign dout = rd_data;
        end
    endgenerate

endmodule

// File: tb/tb_ring_fifo.sv
// Self-checking bench: registered and FWFT instances driven in lockstep against a queue model.
module tb_ring_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] din = '0;

    logic [7:0] dout0, dout1;
    logic       full0, a_full0, empty0, a_empty0, ovf0, udf0;
    logic       full1, a_full1, empty1, a_empty1, ovf1, udf1;
    logic [2:0] count0, count1;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    logic [7:0] q[$];
    logic [7:0] dout_m = '0;
    logic       ovf_m = 1'b0;
    logic       udf_m = 1'b0;

    always #5 clk = ~clk;

    ring_fifo #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_reg (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .din(din), .pop(pop),
        .dout(dout0), .full(full0), .a_full(a_full0), .empty(empty0),
        .a_empty(a_empty0), .count(count0), .ovf(ovf0), .udf(udf0)
    );

    ring_fifo #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .din(din), .pop(pop),
        .dout(dout1), .full(full1), .a_full(a_full1), .empty(empty1),
        .a_empty(a_empty1), .count(count1), .ovf(ovf1), .udf(udf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("count",   32'(count0),   32'(sz));
        chk("full",    32'(full0),    32'(sz == 4));
        chk("empty",   32'(empty0),   32'(sz == 0));
        chk("a_full",  32'(a_full0),  32'(sz >= 3));
        chk("a_empty", 32'(a_empty0), 32'(sz <= 1));
        chk("ovf",     32'(ovf0),     32'(ovf_m));
        chk("udf",     32'(udf0),     32'(udf_m));
        chk("dout",    32'(dout0),    32'(dout_m));
        chk("fw_count",   32'(count1),   32'(sz));
        chk("fw_full",    32'(full1),    32'(sz == 4));
        chk("fw_empty",   32'(empty1),   32'(sz == 0));
        chk("fw_a_full",  32'(a_full1),  32'(sz >= 3));
        chk("fw_a_empty", 32'(a_empty1), 32'(sz <= 1));
        chk("fw_ovf",     32'(ovf1),     32'(ovf_m));
        chk("fw_udf",     32'(udf1),     32'(udf_m));
        if (sz != 0) chk("fw_dout", 32'(dout1), 32'(q[0]));
    endtask

    task automatic model_edge(input logic p, input logic po, input logic [7:0] d, input logic c);
        bit was_full, was_empty;
        was_full  = (q.size() == 4);
        was_empty = (q.size() == 0);
        if (c) begin
            q.delete();
            ovf_m = 1'b0;
            udf_m = 1'b0;
        end else begin
            if (p && was_full) ovf_m = 1'b1;
            if (po && was_empty) udf_m = 1'b1;
            if (po && !was_empty) dout_m = q.pop_front();
            if (p && !was_full) q.push_back(d);
        end
    endtask

    task automatic step(input logic p, input logic po, input logic [7:0] d, input logic c);
        push = p;
        pop  = po;
        din  = d;
        clr  = c;
        @(posedge clk);
        model_edge(p, po, d, c);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        clr  = 1'b0;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        ovf_m  = 1'b0;
        udf_m  = 1'b0;
        dout_m = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic p, po, c;
        int unsigned bias;

        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        check_all();

        // Fill then drain
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hA1 + 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Interleaved wrap traffic
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            step(1'b0, 1'b1, 8'h00, 1'b0);
        end

        // Simultaneous push/pop at count 2, then at full
        step(1'b1, 1'b0, 8'h10, 1'b0);
        step(1'b1, 1'b0, 8'h11, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h20 + 8'(i), 1'b0);
        step(1'b1, 1'b0, 8'h30, 1'b0);
        step(1'b1, 1'b0, 8'h31, 1'b0);
        step(1'b1, 1'b1, 8'h32, 1'b0);

        // Underflow and flush
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h44, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // FWFT visibility without pop
        step(1'b1, 1'b0, 8'h5C, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);

        // Reset between edges with three entries held
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h60 + 8'(i), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'h77, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);

        // Randomized traffic with shifting push/pop bias
        for (int i = 0; i < 600; i++) begin
            bias = ((i / 50) % 2 == 0) ? 70 : 30;
            p  = ($urandom_range(0, 99) < bias);
            po = ($urandom_range(0, 99) < (100 - bias));
            c  = ($urandom_range(0, 63) == 0);
            step(p, po, 8'($urandom), c);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
